// File: rtl/ram_sp_req_ctrl.sv
// Request front-end for a single-port byte-enable RAM: arbitrates a write channel and a
// read-request channel onto the port and returns registered read data through a 2-entry FIFO.
module ram_sp_req_ctrl #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 64
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [DATA_BITS/8-1:0] wr_strb,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic                   rd_req_valid,
  output logic                   rd_req_ready,
  input  logic [ADDR_BITS-1:0]   rd_req_addr,
  output logic                   rd_rsp_valid,
  input  logic                   rd_rsp_ready,
  output logic [DATA_BITS-1:0]   rd_rsp_data,
  output logic                   ram_en,
  output logic [DATA_BITS/8-1:0] ram_we,
  output logic [ADDR_BITS-1:0]   ram_addr,
  output logic [DATA_BITS-1:0]   ram_data_in,
  input  logic [DATA_BITS-1:0]   ram_data_out
);

  // Handshake rule for every channel: a transfer happens on a rising edge where valid and
  // ready are both high; valid may rise without waiting for ready.
  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } grant_e;

  grant_e               last_grant_q, last_grant_d;
  logic                 pending_q, pending_d;
  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [DATA_BITS-1:0] fifo_q [2];

  logic [2:0] occupancy;
  logic       rd_ok;
  logic       wr_fire;
  logic       rd_fire;
  logic       push;
  logic       pop;

  // Read eligibility looks only at registered state, so rd_rsp_ready never reaches the readies.
  always_comb begin
    occupancy = {1'b0, count_q} + {2'b00, pending_q};
    rd_ok     = (occupancy < 3'd2);
  end

  always_comb begin
    wr_ready     = 1'b0;
    rd_req_ready = 1'b0;
    if (!rst_i) begin
      if (wr_valid && rd_req_valid && rd_ok) begin
        if (last_grant_q == GNT_READ) wr_ready     = 1'b1;
        else                          rd_req_ready = 1'b1;
      end else if (wr_valid) begin
        wr_ready = 1'b1;
      end else if (rd_req_valid && rd_ok) begin
        rd_req_ready = 1'b1;
      end
    end
    wr_fire = wr_valid && wr_ready;
    rd_fire = rd_req_valid && rd_req_ready;
  end

  always_comb begin
    ram_en      = wr_fire || rd_fire;
    ram_we      = wr_fire ? wr_strb : '0;
    ram_addr    = rd_fire ? rd_req_addr : wr_addr;
    ram_data_in = wr_data;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (wr_fire)      last_grant_d = GNT_WRITE;
    else if (rd_fire) last_grant_d = GNT_READ;

    // RAM output is only held until the next enable, so capture it the cycle after issue.
    pending_d    = rd_fire;
    push         = pending_q;
    rd_rsp_valid = (count_q != 2'd0) && !rst_i;
    rd_rsp_data  = fifo_q[rd_ptr_q];
    pop          = rd_rsp_valid && rd_rsp_ready;

    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      last_grant_q <= GNT_READ;
      pending_q    <= 1'b0;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      pending_q    <= pending_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst_i) begin
      fifo_q[wr_ptr_q] <= ram_data_out;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst_i)
    !(push && (count_q == 2'd2)));

endmodule

// File: tb/tb_ram_sp_req_ctrl.sv
// Bench for ram_sp_req_ctrl: behavioural RAM behind the DUT, byte-mask reference memory and
// an expected-response queue filled at request acceptance.
module tb_ram_sp_req_ctrl;
  localparam int AB    = 10;
  localparam int DB    = 64;
  localparam int SB    = DB / 8;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          wr_valid, wr_ready;
  logic [AB-1:0] wr_addr;
  logic [SB-1:0] wr_strb;
  logic [DB-1:0] wr_data;
  logic          rd_req_valid, rd_req_ready;
  logic [AB-1:0] rd_req_addr;
  logic          rd_rsp_valid, rd_rsp_ready;
  logic [DB-1:0] rd_rsp_data;
  logic          ram_en;
  logic [SB-1:0] ram_we;
  logic [AB-1:0] ram_addr;
  logic [DB-1:0] ram_data_in;
  logic [DB-1:0] ram_data_out;

  always #5 clk = ~clk;

  ram_sp_req_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_i(rst_i),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_strb(wr_strb), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready), .rd_rsp_data(rd_rsp_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  // Single-port byte-enable RAM with registered read; output holds until the next enable.
  logic [DB-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == '0) ram_data_out <= ram_mem[ram_addr];
      for (int b = 0; b < SB; b++)
        if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_data_in[8*b +: 8];
    end
  end

  logic [DB-1:0] ref_mem [DEPTH];
  logic [DB-1:0] exp_q [$];
  int            errors = 0;
  int            checks = 0;
  int            rd_acc = 0;
  int            rsp_cnt = 0;

  logic          w_f, r_f, rsp_f, rsp_had;
  logic [DB-1:0] rsp_d, rsp_exp;

  // Samples 1 time unit after the negedge drive; updates the reference model for this cycle.
  task automatic sample();
    #1;
    w_f     = wr_valid && wr_ready;
    r_f     = rd_req_valid && rd_req_ready;
    rsp_f   = rd_rsp_valid && rd_rsp_ready;
    rsp_d   = rd_rsp_data;
    rsp_had = 1'b0;
    rsp_exp = '0;
    if (rsp_f) begin
      rsp_cnt++;
      if (exp_q.size() > 0) begin
        rsp_exp = exp_q.pop_front();
        rsp_had = 1'b1;
      end
    end
    if (w_f)
      for (int b = 0; b < SB; b++)
        if (wr_strb[b]) ref_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
    if (r_f) begin
      rd_acc++;
      exp_q.push_back(ref_mem[rd_req_addr]);
    end
  endtask

  task automatic set_idle();
    wr_valid     = 1'b0;
    rd_req_valid = 1'b0;
    rd_rsp_ready = 1'b1;
    wr_addr      = '0;
    wr_strb      = '0;
    wr_data      = '0;
    rd_req_addr  = '0;
  endtask

  task automatic drive_write(input logic [AB-1:0] a, input logic [SB-1:0] s,
                             input logic [DB-1:0] d, output logic fired);
    wr_valid = 1'b1; wr_addr = a; wr_strb = s; wr_data = d; rd_req_valid = 1'b0;
    sample();
    fired = w_f;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic drive_read(input logic [AB-1:0] a, output logic fired);
    rd_req_valid = 1'b1; rd_req_addr = a; wr_valid = 1'b0;
    sample();
    fired = r_f;
    @(negedge clk);
    rd_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [DB-1:0] d, output logic ok, output int lat);
    rd_rsp_ready = 1'b1;
    ok = 1'b0; d = '0; lat = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      sample();
      if (rsp_f) begin ok = 1'b1; d = rsp_d; lat = i + 1; end
      @(negedge clk);
    end
  endtask

  task automatic drain_and_check();
    logic done;
    set_idle();
    done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      sample();
      if (rsp_f) begin
        checks++;
        if (!rsp_had || rsp_d !== rsp_exp) begin
          errors++;
          $display("FAIL drain_rsp: got %h expected %h (had_exp=%0b)", rsp_d, rsp_exp, rsp_had);
        end
      end
      if (exp_q.size() == 0 && !rd_rsp_valid) done = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    wr_valid = 1'b1; rd_req_valid = 1'b1; wr_strb = '1;
    sample();
    checks++;
    if ({wr_ready, rd_req_ready, ram_en, ram_we, rd_rsp_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: wr_rdy=%b rd_rdy=%b en=%b we=%h rsp_v=%b, expected all 0",
               wr_ready, rd_req_ready, ram_en, ram_we, rd_rsp_valid);
    end
    @(negedge clk);
    rst_i = 1'b0;
    set_idle();
    sample();
    checks++;
    if (rd_rsp_valid !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rsp_v=%b en=%b, expected 0 0", rd_rsp_valid, ram_en);
    end
    @(negedge clk);
  endtask

  task automatic preload();
    logic f;
    for (int a = 0; a < 32; a++) drive_write(AB'(a), '1, {$urandom, $urandom}, f);
    drain_and_check();
  endtask

  task automatic test_basic();
    logic f, ok; logic [DB-1:0] d; int lat;
    drive_write(AB'(5), 8'hFF, 64'hDEADBEEF_CAFEF00D, f);
    checks++;
    if (f !== 1'b1) begin errors++; $display("FAIL basic_wr_fire: got %b expected 1", f); end
    drive_read(AB'(5), f);
    checks++;
    if (f !== 1'b1) begin errors++; $display("FAIL basic_rd_fire: got %b expected 1", f); end
    wait_rsp(d, ok, lat);
    checks++;
    if (!ok || d !== 64'hDEADBEEF_CAFEF00D) begin
      errors++; $display("FAIL basic_data: got %h (ok=%b) expected deadbeefcafef00d", d, ok);
    end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_strobe();
    logic f, ok; logic [DB-1:0] d; int lat;
    drive_write(AB'(7), 8'hFF, 64'h1111_1111_1111_1111, f);
    drive_write(AB'(7), 8'h01, 64'h0000_0000_0000_22FF, f);
    drive_read(AB'(7), f);
    wait_rsp(d, ok, lat);
    checks++;
    if (!ok || d !== 64'h1111_1111_1111_11FF) begin
      errors++; $display("FAIL strobe_merge: got %h (ok=%b) expected 11111111111111ff", d, ok);
    end
    drive_write(AB'(7), 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, f);
    checks++;
    if (f !== 1'b1) begin errors++; $display("FAIL strobe0_accept: got %b expected 1", f); end
    drive_read(AB'(7), f);
    wait_rsp(d, ok, lat);
    checks++;
    if (!ok || d !== 64'h1111_1111_1111_11FF) begin
      errors++; $display("FAIL strobe0_unchanged: got %h (ok=%b) expected 11111111111111ff", d, ok);
    end
  endtask

  task automatic test_conflict();
    logic [1:0] exp_g;
    rst_i = 1'b1;
    set_idle();
    @(negedge clk);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_addr = AB'(16 + i); wr_strb = '1; wr_data = {$urandom, $urandom};
      rd_req_valid = 1'b1; rd_req_addr = AB'(i); rd_rsp_ready = 1'b1;
      sample();
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({w_f, r_f} !== exp_g || ram_en !== 1'b1 || (wr_ready && rd_req_ready)) begin
        errors++;
        $display("FAIL conflict_grant%0d: got w/r=%b en=%b, expected w/r=%b en=1", i, {w_f, r_f}, ram_en, exp_g);
      end
      if (rsp_f) begin
        checks++;
        if (!rsp_had || rsp_d !== rsp_exp) begin
          errors++; $display("FAIL conflict_rsp: got %h expected %h", rsp_d, rsp_exp);
        end
      end
      @(negedge clk);
    end
    drain_and_check();
  endtask

  task automatic test_backpressure();
    int k, got;
    set_idle();
    rd_rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      rd_req_valid = 1'b1; rd_req_addr = AB'(k);
      sample();
      if (r_f) k++;
      @(negedge clk);
    end
    sample();
    checks++;
    if (k != 2 || rd_req_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accept: got %0d accepted rdy=%b, expected 2 accepted rdy=0", k, rd_req_ready);
    end
    @(negedge clk);
    rd_rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      rd_req_valid = (k < 4); rd_req_addr = AB'(k);
      sample();
      if (r_f) k++;
      if (rsp_f) begin
        checks++;
        if (rsp_d !== ref_mem[got]) begin
          errors++; $display("FAIL bp_order%0d: got %h expected %h", got, rsp_d, ref_mem[got]);
        end
        got++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 4) begin errors++; $display("FAIL bp_count: got %0d responses expected 4", got); end
    drain_and_check();
  endtask

  task automatic test_reset_inflight();
    logic f, ok; logic [DB-1:0] d; int lat;
    drive_read(AB'(9), f);
    rst_i = 1'b1; wr_valid = 1'b1; rd_req_valid = 1'b1; wr_strb = '1;
    sample();
    checks++;
    if ({wr_ready, rd_req_ready, ram_en, ram_we, rd_rsp_valid} !== '0) begin
      errors++;
      $display("FAIL inflight_rst_outputs: wr_rdy=%b rd_rdy=%b en=%b we=%h rsp_v=%b, expected all 0",
               wr_ready, rd_req_ready, ram_en, ram_we, rd_rsp_valid);
    end
    exp_q.delete();
    @(negedge clk);
    rst_i = 1'b0;
    set_idle();
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++;
      if (rd_rsp_valid !== 1'b0) begin
        errors++; $display("FAIL inflight_dropped%0d: rsp_v=%b expected 0", i, rd_rsp_valid);
      end
      @(negedge clk);
    end
    drive_read(AB'(9), f);
    wait_rsp(d, ok, lat);
    checks++;
    if (!ok || d !== ref_mem[9]) begin
      errors++; $display("FAIL inflight_fresh_read: got %h (ok=%b) expected %h", d, ok, ref_mem[9]);
    end
  endtask

  task automatic test_random(input int n);
    int acc0, rsp0;
    acc0 = rd_acc; rsp0 = rsp_cnt;
    for (int i = 0; i < n; i++) begin
      wr_valid     = 1'($urandom_range(0, 1));
      rd_req_valid = 1'($urandom_range(0, 1));
      rd_rsp_ready = ($urandom_range(0, 3) != 0);
      wr_addr      = AB'($urandom_range(0, 31));
      rd_req_addr  = AB'($urandom_range(0, 31));
      wr_strb      = SB'($urandom_range(0, 255));
      wr_data      = {$urandom, $urandom};
      sample();
      checks++;
      if ((wr_ready && rd_req_ready) || ram_en !== (w_f || r_f) ||
          (w_f && (ram_we !== wr_strb || ram_addr !== wr_addr || ram_data_in !== wr_data)) ||
          (r_f && (ram_we !== '0 || ram_addr !== rd_req_addr))) begin
        errors++;
        $display("FAIL rand_drive%0d: en=%b we=%h addr=%0d rdys=%b%b, expected en=%b for grant w/r=%b%b",
                 i, ram_en, ram_we, ram_addr, wr_ready, rd_req_ready, w_f || r_f, w_f, r_f);
      end
      if (rsp_f) begin
        checks++;
        if (!rsp_had || rsp_d !== rsp_exp) begin
          errors++; $display("FAIL rand_rsp%0d: got %h expected %h (had_exp=%0b)", i, rsp_d, rsp_exp, rsp_had);
        end
      end
      @(negedge clk);
    end
    drain_and_check();
    checks++;
    if ((rsp_cnt - rsp0) != (rd_acc - acc0)) begin
      errors++; $display("FAIL rand_count: got %0d responses expected %0d", rsp_cnt - rsp0, rd_acc - acc0);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    set_idle();
    @(negedge clk);
    test_reset();
    preload();
    test_basic();
    test_strobe();
    test_conflict();
    test_backpressure();
    test_reset_inflight();
    test_random(10000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
